reg_bank_mp: RTL

Parametrised multi-port register bank for the top-level datapath: one write port with byte enables, `NUM_RD` independent registered read ports, and address range checking. It keeps the existing zero-when-not-reading output behaviour. Clearing is done by a sequential clear engine that walks the array one entry per cycle, after reset or on request, so the storage can be inferred as RAM and is not a reset-fanout flop array.

---
 rtl/reg_bank_pkg.sv | 24 ++
 rtl/reg_bank_clear_ctrl.sv | 59 +++++
 rtl/reg_bank_mp.sv | 127 ++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_pkg
//  Brief    : Shared state encoding, default geometry and helpers for reg_bank_mp.
//  Revision : 1.0
// ============================================================================
package reg_bank_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rb_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 100;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_NUM_RD = 2;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_clear_ctrl
//  Brief    : CLEAR/IDLE FSM walking the array one entry per cycle after reset
//             release or a soft-clear request.
//  Revision : 1.0
// ============================================================================
module reg_bank_clear_ctrl
    import reg_bank_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] c_LAST_PTR = ADDR_W'(DEPTH - 1);

    rb_state_e         state_q;
    logic [ADDR_W-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == c_LAST_PTR) begin
                        state_q <= ST_IDLE;
                    end
                    ptr_q <= ptr_q + 1'b1;
                end
                ST_IDLE: begin
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o     = (state_q == ST_CLEAR);
    // The array must stay untouched while reset is held low.
    assign clr_we_o   = busy_o & reset;
    assign clr_addr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/reg_bank_mp.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_mp
//  Brief    : Multi-port register bank: one byte-enabled write port, NUM_RD
//             registered read ports, range checking and a sequential clear.
//  Revision : 1.0
// ============================================================================
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     err
);

    localparam int                NBYTES       = bytes_per_word(DATA_W);
    localparam logic [ADDR_W:0]   c_ADDR_LIMIT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_host_ok;
    logic              w_wr_in_range;
    logic [NUM_RD-1:0] w_rd_in_range;
    logic [NUM_RD-1:0] w_rd_oor;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [NBYTES-1:0] w_mem_wbe;
    logic              err_q;

    reg_bank_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (clr),
        .busy_o     (busy),
        .clr_we_o   (w_clr_we),
        .clr_addr_o (w_clr_addr)
    );

    assign w_host_ok     = reset & ~busy;
    assign w_wr_in_range = ({1'b0, wr_addr} < c_ADDR_LIMIT);

    // Clear and host writes share one physical port; they never overlap in time.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = wr_addr;
        w_mem_wdata = wr_data;
        w_mem_wbe   = wr_be;
        if (w_clr_we) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = w_clr_addr;
            w_mem_wdata = '0;
            w_mem_wbe   = '1;
        end else if (w_host_ok && wr_en && w_wr_in_range) begin
            w_mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_mem_wbe[b]) begin
                    mem_q[w_mem_waddr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] data_q;
        logic              valid_q;

        assign w_addr           = rd_addr[p*ADDR_W +: ADDR_W];
        assign w_rd_in_range[p] = ({1'b0, w_addr} < c_ADDR_LIMIT);
        assign w_rd_oor[p]      = rd_en[p] & ~w_rd_in_range[p];

        // Non-blocking read of mem_q yields the pre-write value on a collision.
        always_ff @(posedge clk) begin
            if (!reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (w_host_ok && rd_en[p] && w_rd_in_range[p]) begin
                data_q  <= mem_q[w_addr];
                valid_q <= 1'b1;
            end else begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data_q;
        assign rd_valid[p]                 = valid_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= w_host_ok & ((wr_en & ~w_wr_in_range) | (|w_rd_oor));
        end
    end

    assign err = err_q;

endmodule
`default_nettype wire
